rx_deserializer_mc: RTL and testbench
=====================================

Name: rx_deserializer_mc

Overview:
- Multi-channel successor to the single-sensor pixel deserializer.
- Accepts C_CHANNELS independent decoded serial bit streams, one per sensor RX decoder, all in the sampling clock domain.
- Frames each stream into 12-bit pixel words (start bit, D_WIDTH data bits, stop bit), checks framing and tags each pixel with column and row.
- Buffers each channel in a small FIFO and merges all channels round-robin onto one valid/ready pixel stream feeding the line-period and output logic.

Parameters:
- C_CHANNELS, 2, number of sensor streams (1..8).
- D_WIDTH, 10, pixel data bits per word; word length is D_WIDTH+2.
- C_COLUMNS, 320, pixels per line.
- C_ROWS, 320, lines per frame.
- C_FIFO_DEPTH, 4, words per channel FIFO (power of 2, ≥2).

Ports:
- CLOCK  in  1  sampling clock; all logic is in this single domain.
- RESET  in  1  asynchronous, active-low reset.
- FRAME_START  in  C_CHANNELS  per-channel frame-start pulse from the decoder.
- SER_INPUT  in  C_CHANNELS  per-channel decoded serial bit.
- SER_INPUT_EN  in  C_CHANNELS  per-channel bit-valid strobe.
- ERR_CLEAR  in  1  clears all sticky OVERFLOW bits.
- PAR_READY  in  1  downstream accepts the current word.
- PAR_OUTPUT  out  D_WIDTH  pixel data.
- PAR_OUTPUT_EN  out  1  output valid.
- PAR_CHANNEL  out  max(1,clog2(C_CHANNELS))  source channel of the current word.
- PAR_COL  out  clog2(C_COLUMNS)  column tag.
- PAR_ROW  out  clog2(C_ROWS)  row tag.
- LINE_END  out  1  current word is the last column of its line.
- FRAME_END  out  1  current word is the last column of the last row.
- PIXEL_ERROR  out  C_CHANNELS  one-cycle pulse per framing error.
- OVERFLOW  out  C_CHANNELS  sticky flag: a FIFO-full drop occurred.

Behaviour:
- Reset (RESET low, async): all outputs 0; shift registers, bit counters, column/row counters, FIFOs and round-robin pointer cleared; pointer starts at channel 0.
- Framing, per channel:
  - On SER_INPUT_EN, shift SER_INPUT into a (D_WIDTH+2)-bit register, first bit received becomes the MSB; increment the bit counter.
  - When the counter reaches D_WIDTH+2 the word is complete; the counter returns to 0 on the same edge.
  - Good word: MSB==1 and LSB==0. Push data = word[D_WIDTH:1] with the current col/row.
  - Bad word: no push, PIXEL_ERROR[ch] pulses for 1 cycle. The column counter still advances so line alignment is kept.
- Position counters, per channel:
  - Column advances on every completed word. At C_COLUMNS-1 it wraps to 0 and the row increments.
  - Row wraps from C_ROWS-1 to 0.
- FRAME_START[ch]: clears the bit counter, shift register, column and row of that channel. It has priority over a same-cycle SER_INPUT_EN; that bit is discarded. It does not flush the channel FIFO.
- FIFO, per channel:
  - Push when full: the word is dropped and OVERFLOW[ch] is set.
  - ERR_CLEAR clears OVERFLOW. A same-cycle set wins over clear.
  - Simultaneous push and pop on a full FIFO is permitted and is not an overflow.
- Output stage:
  - One output register. It loads when empty, or when PAR_OUTPUT_EN && PAR_READY.
  - Source is the first non-empty FIFO at or after the round-robin pointer. After each grant the pointer moves to granted channel + 1, wrapping modulo C_CHANNELS.
  - While PAR_OUTPUT_EN=1 and PAR_READY=0, all output fields hold stable.
  - LINE_END and FRAME_END are tag bits stored with the word and are qualified by PAR_OUTPUT_EN.
- Latency: stop bit sampled at edge k → FIFO entry valid after edge k+1 → PAR_OUTPUT_EN high after edge k+2 when the FIFO and output register were empty and the channel holds the pointer. Sustained throughput is 1 word/cycle aggregate.
- Reset mid-word or mid-handshake drops all in-flight data; no partial word is emitted.

Optional Feature:
- Macro RX_DESER_MC_STATS_EN.
- Defined:
  - Adds output ERR_COUNT [16*C_CHANNELS-1:0], one 16-bit counter per channel.
  - Each counter increments on every PIXEL_ERROR pulse, saturates at 0xFFFF, and is cleared by ERR_CLEAR or reset.
  - An increment in the same cycle as ERR_CLEAR yields 1.
- Not defined: the port and counters are absent; all other behaviour is identical.

Test Plan:
1. Single channel, C_CHANNELS=2, channel 0 sends word 1_1010101010_0, PAR_READY=1 → PAR_OUTPUT=0x2AA, PAR_CHANNEL=0, PAR_COL=0, PAR_ROW=0, valid exactly 2 cycles after the stop-bit edge.
2. Channel 1 sends a word with stop bit 1 → PIXEL_ERROR[1] pulses 1 cycle, no output word, next good word carries PAR_COL=1; with RX_DESER_MC_STATS_EN, ERR_COUNT[31:16]=1.
3. Both channels complete words on the same edge, pointer=0 → outputs channel 0 then channel 1 on consecutive cycles; next simultaneous pair → channel 0 then channel 1 again.
4. PAR_READY=0, channel 0 streams 6 words with C_FIFO_DEPTH=4 → 1 word held in the output register, 4 in the FIFO, 6th dropped, OVERFLOW[0]=1; ERR_CLEAR pulse → OVERFLOW[0]=0.
5. Stream 320×320 good words on channel 0 → LINE_END on every PAR_COL=319, FRAME_END only at row 319/col 319, next word tagged row 0/col 0.
6. FRAME_START[0] after 5 bits of a word, then a full good word, with RESET pulsed low mid-handshake in a second run → the partial word is discarded, the new word is tagged col 0/row 0; after reset all outputs are 0 and the FIFOs are empty.

Source files
------------

// File: rtl/rx_deserializer_mc.sv
`default_nettype none
// ============================================================================
// Module      : rx_deserializer_mc
// Description : Frames C_CHANNELS serial streams into tagged pixel words,
//               buffers each channel in a FIFO and merges them round-robin
//               onto a single valid/ready output. Optional per-channel error
//               counters are enabled with RX_DESER_MC_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_deserializer_mc #(
   parameter int C_CHANNELS   = 2,
   parameter int D_WIDTH      = 10,
   parameter int C_COLUMNS    = 320,
   parameter int C_ROWS       = 320,
   parameter int C_FIFO_DEPTH = 4,
   localparam int CH_W  = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1,
   localparam int COL_W = $clog2(C_COLUMNS),
   localparam int ROW_W = $clog2(C_ROWS)
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic [C_CHANNELS-1:0] FRAME_START,
   input  logic [C_CHANNELS-1:0] SER_INPUT,
   input  logic [C_CHANNELS-1:0] SER_INPUT_EN,
   input  logic                  ERR_CLEAR,
   input  logic                  PAR_READY,
   output logic [D_WIDTH-1:0]    PAR_OUTPUT,
   output logic                  PAR_OUTPUT_EN,
   output logic [CH_W-1:0]       PAR_CHANNEL,
   output logic [COL_W-1:0]      PAR_COL,
   output logic [ROW_W-1:0]      PAR_ROW,
   output logic                  LINE_END,
   output logic                  FRAME_END,
   output logic [C_CHANNELS-1:0] PIXEL_ERROR,
   output logic [C_CHANNELS-1:0] OVERFLOW
`ifdef RX_DESER_MC_STATS_EN
   ,
   output logic [16*C_CHANNELS-1:0] ERR_COUNT
`endif
);

   localparam int WORD_W = D_WIDTH + 2;
   localparam int BCNT_W = $clog2(WORD_W + 1);
   localparam int ENT_W  = D_WIDTH + COL_W + ROW_W + 2;
   localparam int PTR_W  = $clog2(C_FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   logic [C_CHANNELS-1:0]            fifo_empty;
   logic [C_CHANNELS-1:0][ENT_W-1:0] fifo_head;
   logic [C_CHANNELS-1:0]            pop;

   logic                 out_vld;
   logic [D_WIDTH-1:0]   out_data;
   logic [CH_W-1:0]      out_ch;
   logic [COL_W-1:0]     out_col;
   logic [ROW_W-1:0]     out_row;
   logic                 out_le;
   logic                 out_fe;
   logic [CH_W-1:0]      rr_ptr;
   logic [CH_W-1:0]      grant;
   logic                 grant_vld;
   logic [CH_W:0]        cand;
   logic                 load;

   for (genvar ch = 0; ch < C_CHANNELS; ch++) begin : g_ch
      // Only the first WORD_W-1 bits are held; the arriving bit completes the word.
      logic [WORD_W-2:0]   shift_q;
      logic [BCNT_W-1:0]   bit_cnt;
      logic [COL_W-1:0]    col;
      logic [ROW_W-1:0]    row;
      logic                push_vld;
      logic [ENT_W-1:0]    push_ent;
      logic                perr;
      logic [ENT_W-1:0]    mem [C_FIFO_DEPTH];
      logic [PTR_W-1:0]    wr_ptr;
      logic [PTR_W-1:0]    rd_ptr;
      logic [CNT_W-1:0]    count;
      logic                ovf;
      logic [WORD_W-1:0]   word_nxt;
      logic                word_done;
      logic                line_last;
      logic                row_last;
      logic                fifo_full;
      logic                do_push;

      assign word_nxt  = {shift_q, SER_INPUT[ch]};
      assign word_done = SER_INPUT_EN[ch] && !FRAME_START[ch] &&
                         (bit_cnt == BCNT_W'(WORD_W - 1));
      assign line_last = (col == COL_W'(C_COLUMNS - 1));
      assign row_last  = (row == ROW_W'(C_ROWS - 1));

      always_ff @(posedge CLOCK or negedge RESET) begin
         if (!RESET) begin
            shift_q  <= '0;
            bit_cnt  <= '0;
            col      <= '0;
            row      <= '0;
            push_vld <= 1'b0;
            push_ent <= '0;
            perr     <= 1'b0;
         end else begin
            push_vld <= 1'b0;
            perr     <= 1'b0;
            if (FRAME_START[ch]) begin
               shift_q <= '0;
               bit_cnt <= '0;
               col     <= '0;
               row     <= '0;
            end else if (SER_INPUT_EN[ch]) begin
               shift_q <= word_nxt[WORD_W-2:0];
               if (word_done) begin
                  bit_cnt <= '0;
                  if (word_nxt[WORD_W-1] && !word_nxt[0]) begin
                     push_vld <= 1'b1;
                     push_ent <= {word_nxt[D_WIDTH:1], col, row, line_last,
                                  line_last && row_last};
                  end else begin
                     perr <= 1'b1;
                  end
                  // Bad words still occupy a column slot to keep line alignment.
                  if (line_last) begin
                     col <= '0;
                     row <= row_last ? '0 : row + ROW_W'(1);
                  end else begin
                     col <= col + COL_W'(1);
                  end
               end else begin
                  bit_cnt <= bit_cnt + BCNT_W'(1);
               end
            end
         end
      end

      assign fifo_full = (count == CNT_W'(C_FIFO_DEPTH));
      assign do_push   = push_vld && (!fifo_full || pop[ch]);

      always_ff @(posedge CLOCK) begin
         if (do_push) mem[wr_ptr] <= push_ent;
      end

      always_ff @(posedge CLOCK or negedge RESET) begin
         if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop[ch]) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, pop[ch]})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
            if (push_vld && !do_push) ovf <= 1'b1;
            else if (ERR_CLEAR)       ovf <= 1'b0;
         end
      end

      assign fifo_empty[ch]  = (count == '0);
      assign fifo_head[ch]   = mem[rd_ptr];
      assign PIXEL_ERROR[ch] = perr;
      assign OVERFLOW[ch]    = ovf;

`ifdef RX_DESER_MC_STATS_EN
      logic [15:0] err_cnt;

      always_ff @(posedge CLOCK or negedge RESET) begin
         if (!RESET) begin
            err_cnt <= '0;
         end else if (perr) begin
            if (ERR_CLEAR)                err_cnt <= 16'd1;
            else if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
         end else if (ERR_CLEAR) begin
            err_cnt <= '0;
         end
      end

      assign ERR_COUNT[16*ch +: 16] = err_cnt;
`endif
   end

   assign load = !out_vld || PAR_READY;

   // First non-empty channel at or after the pointer, scanning with wrap.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      cand      = '0;
      for (int i = 0; i < C_CHANNELS; i++) begin
         cand = {1'b0, rr_ptr} + (CH_W+1)'(i);
         if (cand >= (CH_W+1)'(C_CHANNELS)) cand = cand - (CH_W+1)'(C_CHANNELS);
         if (!grant_vld && !fifo_empty[cand[CH_W-1:0]]) begin
            grant_vld = 1'b1;
            grant     = cand[CH_W-1:0];
         end
      end
   end

   always_comb begin
      pop = '0;
      if (load && grant_vld) pop[grant] = 1'b1;
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         out_vld  <= 1'b0;
         out_data <= '0;
         out_ch   <= '0;
         out_col  <= '0;
         out_row  <= '0;
         out_le   <= 1'b0;
         out_fe   <= 1'b0;
         rr_ptr   <= '0;
      end else if (load) begin
         out_vld <= grant_vld;
         if (grant_vld) begin
            {out_data, out_col, out_row, out_le, out_fe} <= fifo_head[grant];
            out_ch <= grant;
            rr_ptr <= (grant == CH_W'(C_CHANNELS - 1)) ? '0 : grant + CH_W'(1);
         end
      end
   end

   assign PAR_OUTPUT    = out_data;
   assign PAR_OUTPUT_EN = out_vld;
   assign PAR_CHANNEL   = out_ch;
   assign PAR_COL       = out_col;
   assign PAR_ROW       = out_row;
   assign LINE_END      = out_vld && out_le;
   assign FRAME_END     = out_vld && out_fe;

endmodule
`default_nettype wire

// File: tb/tb_rx_deserializer_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_deserializer_mc
// Description : Self-checking bench for rx_deserializer_mc with a bit-level
//               reference model and scoreboard (RX_DESER_MC_STATS_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_deserializer_mc;

   // Small frame geometry keeps a full-frame pass short.
   localparam int CH    = 2;
   localparam int DW    = 10;
   localparam int WW    = DW + 2;
   localparam int COLS  = 10;
   localparam int ROWS  = 4;
   localparam int DEPTH = 4;
   localparam int CH_W  = 1;
   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);

   logic              CLOCK = 1'b0;
   logic              RESET = 1'b1;
   logic [CH-1:0]     FRAME_START;
   logic [CH-1:0]     SER_INPUT;
   logic [CH-1:0]     SER_INPUT_EN;
   logic              ERR_CLEAR;
   logic              PAR_READY;
   logic [DW-1:0]     PAR_OUTPUT;
   logic              PAR_OUTPUT_EN;
   logic [CH_W-1:0]   PAR_CHANNEL;
   logic [COL_W-1:0]  PAR_COL;
   logic [ROW_W-1:0]  PAR_ROW;
   logic              LINE_END;
   logic              FRAME_END;
   logic [CH-1:0]     PIXEL_ERROR;
   logic [CH-1:0]     OVERFLOW;
`ifdef RX_DESER_MC_STATS_EN
   logic [16*CH-1:0]  ERR_COUNT;
`endif

   rx_deserializer_mc #(
      .C_CHANNELS  (CH),
      .D_WIDTH     (DW),
      .C_COLUMNS   (COLS),
      .C_ROWS      (ROWS),
      .C_FIFO_DEPTH(DEPTH)
   ) dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .FRAME_START  (FRAME_START),
      .SER_INPUT    (SER_INPUT),
      .SER_INPUT_EN (SER_INPUT_EN),
      .ERR_CLEAR    (ERR_CLEAR),
      .PAR_READY    (PAR_READY),
      .PAR_OUTPUT   (PAR_OUTPUT),
      .PAR_OUTPUT_EN(PAR_OUTPUT_EN),
      .PAR_CHANNEL  (PAR_CHANNEL),
      .PAR_COL      (PAR_COL),
      .PAR_ROW      (PAR_ROW),
      .LINE_END     (LINE_END),
      .FRAME_END    (FRAME_END),
      .PIXEL_ERROR  (PIXEL_ERROR),
      .OVERFLOW     (OVERFLOW)
`ifdef RX_DESER_MC_STATS_EN
      ,
      .ERR_COUNT    (ERR_COUNT)
`endif
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      int           ch;
      logic [DW-1:0] data;
      int           col;
      int           row;
      bit           le;
      bit           fe;
   } ent_t;

   typedef struct {
      int            ch;
      logic [WW-1:0] word;
      bit            bad;
      logic [DW-1:0] data;
      int            col;
   } vec_t;

   int            checks = 0;
   int            errors = 0;
   bit            sb_on  = 1'b1;
   ent_t          exp_q[$];
   logic [DW-1:0] got_q[$];
   int            nbits    [CH];
   int            widx     [CH];
   logic [WW-1:0] acc      [CH];
   bit            exp_perr [CH];
   int            exp_ecnt [CH];
   int            hs_count, le_seen, fe_seen, last_col, last_row;
   logic [WW-1:0] drv_word [CH];
   int            drv_idx  [CH];
   vec_t          vecs     [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      got_q.delete();
      for (int c = 0; c < CH; c++) begin
         nbits[c]    = 0;
         widx[c]     = 0;
         acc[c]      = '0;
         exp_perr[c] = 1'b0;
         exp_ecnt[c] = 0;
      end
   endtask

   // Match a delivered word against the oldest pending word of its channel.
   task automatic score(input int ch, input logic [DW-1:0] d, input int col,
                        input int row, input bit le, input bit fe);
      int k;
      k = -1;
      for (int i = 0; i < exp_q.size(); i++)
         if (k < 0 && exp_q[i].ch == ch) k = i;
      if (k < 0) begin
         checks++;
         errors++;
         $display("FAIL sb_unexpected: got word 0x%0h on ch %0d, expected none", d, ch);
      end else begin
         chk("sb_data", d,   exp_q[k].data);
         chk("sb_col",  col, exp_q[k].col);
         chk("sb_row",  row, exp_q[k].row);
         chk("sb_le",   le,  exp_q[k].le);
         chk("sb_fe",   fe,  exp_q[k].fe);
         exp_q.delete(k);
      end
   endtask

   task automatic tick();
      logic             pre_vld, pre_rdy, pre_le, pre_fe;
      logic [CH_W-1:0]  pre_ch;
      logic [DW-1:0]    pre_d;
      logic [COL_W-1:0] pre_col;
      logic [ROW_W-1:0] pre_row;
      bit               pre_perr [CH];
      ent_t             e;
      pre_vld = PAR_OUTPUT_EN;
      pre_rdy = PAR_READY;
      pre_ch  = PAR_CHANNEL;
      pre_d   = PAR_OUTPUT;
      pre_col = PAR_COL;
      pre_row = PAR_ROW;
      pre_le  = LINE_END;
      pre_fe  = FRAME_END;
      if (pre_vld && pre_rdy) begin
         hs_count++;
         if (pre_le) le_seen++;
         if (pre_fe) fe_seen++;
         last_col = int'(pre_col);
         last_row = int'(pre_row);
         if (sb_on) score(int'(pre_ch), pre_d, int'(pre_col), int'(pre_row), pre_le, pre_fe);
         else       got_q.push_back(pre_d);
      end
      @(posedge CLOCK);
      #1;
      for (int c = 0; c < CH; c++) begin
         pre_perr[c] = exp_perr[c];
         exp_perr[c] = 1'b0;
         if (ERR_CLEAR)                              exp_ecnt[c] = pre_perr[c] ? 1 : 0;
         else if (pre_perr[c] && exp_ecnt[c] < 65535) exp_ecnt[c]++;
         if (FRAME_START[c]) begin
            nbits[c] = 0;
            widx[c]  = 0;
         end else if (SER_INPUT_EN[c]) begin
            acc[c] = {acc[c][WW-2:0], SER_INPUT[c]};
            nbits[c]++;
            if (nbits[c] == WW) begin
               nbits[c] = 0;
               if (acc[c][WW-1] && !acc[c][0]) begin
                  e.ch   = c;
                  e.data = acc[c][DW:1];
                  e.col  = widx[c] % COLS;
                  e.row  = (widx[c] / COLS) % ROWS;
                  e.le   = (e.col == COLS - 1);
                  e.fe   = e.le && (e.row == ROWS - 1);
                  exp_q.push_back(e);
               end else begin
                  exp_perr[c] = 1'b1;
               end
               widx[c]++;
            end
         end
         chk("pixel_error", PIXEL_ERROR[c], exp_perr[c]);
`ifdef RX_DESER_MC_STATS_EN
         chk("err_count", ERR_COUNT[16*c +: 16], exp_ecnt[c]);
`endif
      end
      if (sb_on) chk("overflow_idle", OVERFLOW, 0);
      if (pre_vld && !pre_rdy) begin
         chk("hold_valid", PAR_OUTPUT_EN, 1);
         chk("hold_fields", {PAR_OUTPUT, PAR_CHANNEL, PAR_COL, PAR_ROW, LINE_END, FRAME_END},
             {pre_d, pre_ch, pre_col, pre_row, pre_le, pre_fe});
      end
   endtask

   task automatic send_word(input int ch, input logic [WW-1:0] w);
      for (int i = WW - 1; i >= 0; i--) begin
         SER_INPUT_EN[ch] = 1'b1;
         SER_INPUT[ch]    = w[i];
         tick();
      end
      SER_INPUT_EN[ch] = 1'b0;
   endtask

   task automatic send_pair(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
      for (int i = WW - 1; i >= 0; i--) begin
         SER_INPUT_EN = 2'b11;
         SER_INPUT    = {w1[i], w0[i]};
         tick();
      end
      SER_INPUT_EN = '0;
   endtask

   function automatic logic [WW-1:0] rand_word();
      logic [DW-1:0] d;
      logic          st, sp;
      d  = DW'($urandom);
      st = 1'b1;
      sp = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
         case ($urandom_range(0, 2))
            0:       st = 1'b0;
            1:       sp = 1'b1;
            default: begin st = 1'b0; sp = 1'b1; end
         endcase
      end
      return {st, d, sp};
   endfunction

   task automatic chk_all_zero(input string name);
      chk(name, {PAR_OUTPUT, PAR_OUTPUT_EN, PAR_CHANNEL, PAR_COL, PAR_ROW,
                 LINE_END, FRAME_END, PIXEL_ERROR, OVERFLOW}, 0);
`ifdef RX_DESER_MC_STATS_EN
      chk({name, "_errcnt"}, ERR_COUNT, 0);
`endif
   endtask

   initial begin
      vecs[0] = '{0, 12'hD54, 1'b0, 10'h2AA, 0};
      vecs[1] = '{1, 12'h801, 1'b1, 10'h000, 0};
      vecs[2] = '{1, 12'hAAA, 1'b0, 10'h155, 1};
      vecs[3] = '{0, 12'h7FE, 1'b1, 10'h000, 1};
      vecs[4] = '{0, 12'hFFE, 1'b0, 10'h3FF, 2};
      vecs[5] = '{0, 12'h800, 1'b0, 10'h000, 3};
      vecs[6] = '{1, 12'h667, 1'b1, 10'h000, 2};
      vecs[7] = '{1, 12'h802, 1'b0, 10'h001, 3};

      FRAME_START  = '0;
      SER_INPUT    = '0;
      SER_INPUT_EN = '0;
      ERR_CLEAR    = 1'b0;
      PAR_READY    = 1'b1;
      hs_count = 0; le_seen = 0; fe_seen = 0; last_col = 0; last_row = 0;
      model_clear();
      #1 RESET = 1'b0;
      repeat (3) @(posedge CLOCK);
      #1;
      chk_all_zero("reset_state");
      RESET = 1'b1;
      tick();

      // Single words, latency, framing errors and column advance on errors.
      for (int v = 0; v < 8; v++) begin
         send_word(vecs[v].ch, vecs[v].word);
         chk("vec_perr", PIXEL_ERROR[vecs[v].ch], vecs[v].bad);
         tick();
         chk("vec_lat1_valid", PAR_OUTPUT_EN, 0);
         tick();
         if (vecs[v].bad) begin
            chk("vec_bad_no_out", PAR_OUTPUT_EN, 0);
         end else begin
            chk("vec_valid", PAR_OUTPUT_EN, 1);
            chk("vec_data", PAR_OUTPUT, vecs[v].data);
            chk("vec_chan", PAR_CHANNEL, vecs[v].ch);
            chk("vec_col", PAR_COL, vecs[v].col);
            chk("vec_row", PAR_ROW, 0);
         end
      end

      // Simultaneous completions are granted channel 0 then channel 1, twice.
      for (int p = 0; p < 2; p++) begin
         send_pair({1'b1, 10'(10'h050 + p), 1'b0}, {1'b1, 10'(10'h060 + p), 1'b0});
         tick();
         tick();
         chk("pair_first_valid", PAR_OUTPUT_EN, 1);
         chk("pair_first_chan", PAR_CHANNEL, 0);
         chk("pair_first_data", PAR_OUTPUT, 10'h050 + p);
         tick();
         chk("pair_second_valid", PAR_OUTPUT_EN, 1);
         chk("pair_second_chan", PAR_CHANNEL, 1);
         chk("pair_second_data", PAR_OUTPUT, 10'h060 + p);
      end
      repeat (2) tick();

      // A full frame plus one word on channel 0.
      FRAME_START[0] = 1'b1;
      tick();
      FRAME_START[0] = 1'b0;
      le_seen = 0;
      fe_seen = 0;
      for (int i = 0; i < COLS * ROWS + 1; i++) send_word(0, {1'b1, 10'(i), 1'b0});
      repeat (3) tick();
      chk("frame_line_ends", le_seen, ROWS);
      chk("frame_frame_ends", fe_seen, 1);
      chk("frame_wrap_col", last_col, 0);
      chk("frame_wrap_row", last_row, 0);

      // Frame start after 5 bits, with a same-cycle bit that must be discarded.
      for (int i = WW - 1; i > WW - 6; i--) begin
         SER_INPUT_EN[0] = 1'b1;
         SER_INPUT[0]    = vecs[0].word[i];
         tick();
      end
      FRAME_START[0]  = 1'b1;
      SER_INPUT[0]    = 1'b1;
      tick();
      FRAME_START[0]  = 1'b0;
      SER_INPUT_EN[0] = 1'b0;
      send_word(0, 12'h9E0);
      tick();
      tick();
      chk("fs_valid", PAR_OUTPUT_EN, 1);
      chk("fs_data", PAR_OUTPUT, 10'h0F0);
      chk("fs_col", PAR_COL, 0);
      chk("fs_row", PAR_ROW, 0);
      repeat (2) tick();

      // Overflow: 1 in output register, DEPTH in FIFO, the next one dropped.
      sb_on     = 1'b0;
      PAR_READY = 1'b0;
      for (int i = 1; i <= 6; i++) send_word(0, {1'b1, 10'(10'h100 + i), 1'b0});
      tick();
      tick();
      chk("ovf_set", OVERFLOW[0], 1);
      chk("ovf_other_chan", OVERFLOW[1], 0);
      chk("ovf_held_valid", PAR_OUTPUT_EN, 1);
      chk("ovf_held_data", PAR_OUTPUT, 10'h101);
      ERR_CLEAR = 1'b1;
      tick();
      ERR_CLEAR = 1'b0;
      chk("ovf_clear", OVERFLOW[0], 0);
      send_word(0, {1'b1, 10'h107, 1'b0});
      got_q.delete();
      PAR_READY = 1'b1;
      tick();
      chk("full_push_pop_no_ovf", OVERFLOW[0], 0);
      repeat (10) tick();
      chk("ovf_drain_count", got_q.size(), 6);
      for (int i = 0; i < 6 && i < got_q.size(); i++)
         chk("ovf_drain_data", got_q[i], (i < 5) ? (10'h101 + i) : 10'h107);

      // Reset while a word is stalled, another is queued and one is partial.
      PAR_READY = 1'b0;
      send_word(0, 12'hAAA);
      send_word(0, 12'hD54);
      for (int i = 0; i < 5; i++) begin
         SER_INPUT_EN[1] = 1'b1;
         SER_INPUT[1]    = 1'b1;
         tick();
      end
      tick();
      chk("pre_reset_valid", PAR_OUTPUT_EN, 1);
      RESET = 1'b0;
      #2;
      chk_all_zero("async_reset");
      @(posedge CLOCK);
      #1;
      @(posedge CLOCK);
      #1;
      SER_INPUT_EN = '0;
      SER_INPUT    = '0;
      model_clear();
      sb_on = 1'b1;
      RESET = 1'b1;
      chk_all_zero("post_reset");
      PAR_READY = 1'b1;
      hs_count  = 0;
      repeat (15) tick();
      chk("reset_fifos_empty", hs_count, 0);
      send_word(1, 12'h802);
      tick();
      tick();
      chk("post_reset_valid", PAR_OUTPUT_EN, 1);
      chk("post_reset_chan", PAR_CHANNEL, 1);
      chk("post_reset_col", PAR_COL, 0);
      chk("post_reset_row", PAR_ROW, 0);
      tick();

      // Randomized traffic against the reference model.
      for (int c = 0; c < CH; c++) begin
         drv_word[c] = rand_word();
         drv_idx[c]  = 0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int c = 0; c < CH; c++) begin
            FRAME_START[c]  = ($urandom_range(0, 199) == 0);
            SER_INPUT_EN[c] = ($urandom_range(0, 2) != 0);
            SER_INPUT[c]    = drv_word[c][WW - 1 - drv_idx[c]];
            if (FRAME_START[c]) begin
               drv_idx[c]  = 0;
               drv_word[c] = rand_word();
            end else if (SER_INPUT_EN[c]) begin
               drv_idx[c]++;
               if (drv_idx[c] == WW) begin
                  drv_idx[c]  = 0;
                  drv_word[c] = rand_word();
               end
            end
         end
         PAR_READY = ($urandom_range(0, 3) != 0);
         ERR_CLEAR = ($urandom_range(0, 63) == 0);
         tick();
      end
      FRAME_START  = '0;
      SER_INPUT_EN = '0;
      ERR_CLEAR    = 1'b0;
      PAR_READY    = 1'b1;
      repeat (30) tick();
      chk("drain_all_delivered", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
